// File: rtl/nonce_uart_tx.sv
// nonce_uart_tx
//   Returns a winning 32-bit nonce to the host as 8-N-1 UART bytes.
//   The bytes go out most significant byte first. Each byte is a start bit,
//   eight data bits LSB first and one stop bit. There is no idle gap between
//   bytes. A transmission starts only on a rising edge of `send` seen in IDLE.
//
//   Optional feature: define NONCE_TX_CHECKSUM_EN to append a fifth byte.
//   That byte is the XOR of the four nonce bytes.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (2..65535)
// Ports
//   clock   in   UART domain clock
//   reset   in   synchronous, active-high reset
//   send    in   transmit request (rising edge triggers)
//   nonce   in   32-bit nonce, sampled on an accepted trigger
//   txd     out  serial line, idles high
//   busy    out  high while a frame is in flight
//   done    out  one-cycle pulse after the final stop bit
module nonce_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        send,
  input  logic [31:0] nonce,
  output logic        txd,
  output logic        busy,
  output logic        done
);

`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NUM_BYTES = 5;
`else
  localparam int NUM_BYTES = 4;
`endif
  localparam int          SHIFT_W    = 8 * NUM_BYTES;
  localparam logic [15:0] LAST_COUNT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BYTE  = 3'(NUM_BYTES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} txState_t;

  txState_t             state;
  logic                 sendPrev;
  logic [15:0]          bitCount;
  logic [2:0]           byteIndex;
  logic [2:0]           bitIndex;
  logic [SHIFT_W-1:0]   shiftReg;
  logic [SHIFT_W-1:0]   loadValue;
  logic [7:0]           curByte;
  logic                 trigger;
  logic                 bitDone;

  // The byte on the wire is always the top byte of the shift register.
  assign curByte = shiftReg[SHIFT_W-1 -: 8];
  assign trigger = send & ~sendPrev;
  assign bitDone = (bitCount == LAST_COUNT);

`ifdef NONCE_TX_CHECKSUM_EN
  // The checksum is taken from the same nonce value that is latched, so it
  // always matches the bytes actually sent.
  assign loadValue = {nonce, nonce[31:24] ^ nonce[23:16] ^ nonce[15:8] ^ nonce[7:0]};
`else
  assign loadValue = nonce;
`endif

  // NOTE: the frame data register carries no reset. Its contents matter
  // only after a trigger loads it, so clearing it would add reset fan-out
  // for no functional gain.
  always_ff @(posedge clock) begin
    if (state == IDLE && trigger) begin
      shiftReg <= loadValue;
    end else if (state == STOP && bitDone && byteIndex != LAST_BYTE) begin
      shiftReg <= {shiftReg[SHIFT_W-9:0], 8'h00};
    end
  end

  // NOTE: all state updates use non-blocking assignments. Every register
  // then sees the values from before the edge, whatever the statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      sendPrev  <= 1'b1;   // a send held high through reset must not fire
      bitCount  <= '0;
      byteIndex <= '0;
      bitIndex  <= '0;
    end else begin
      sendPrev <= send;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            state     <= START;
            txd       <= 1'b0;
            busy      <= 1'b1;
            bitCount  <= '0;
            byteIndex <= '0;
          end
        end
        START: begin
          if (bitDone) begin
            bitCount <= '0;
            bitIndex <= '0;
            txd      <= curByte[0];
            state    <= DATA;
          end else begin
            bitCount <= bitCount + 16'd1;
          end
        end
        DATA: begin
          if (bitDone) begin
            bitCount <= '0;
            if (bitIndex == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bitIndex <= bitIndex + 3'd1;
              txd      <= curByte[bitIndex + 3'd1];
            end
          end else begin
            bitCount <= bitCount + 16'd1;
          end
        end
        STOP: begin
          if (bitDone) begin
            bitCount <= '0;
            if (byteIndex == LAST_BYTE) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              // The next start bit follows immediately, with no idle gap.
              byteIndex <= byteIndex + 3'd1;
              txd       <= 1'b0;
              state     <= START;
            end
          end else begin
            bitCount <= bitCount + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_uart_tx.sv
// tb_nonce_uart_tx
//   Self-checking bench for nonce_uart_tx. It builds the expected line level
//   for every cycle of a frame from the byte list and the 8-N-1 framing
//   rules. It also decodes the bytes seen at mid-bit and checks done/busy
//   timing, retrigger rules, nonce stability and reset behaviour.
module tb_nonce_uart_tx;

  localparam int C = 4;
`ifdef NONCE_TX_CHECKSUM_EN
  localparam int NB = 5;
`else
  localparam int NB = 4;
`endif
  localparam int FRAME = NB * 10 * C;

  logic        clock = 1'b0;
  logic        reset;
  logic        send;
  logic [31:0] nonce;
  logic        txd;
  logic        busy;
  logic        done;

  int          errors = 0;
  int          checks = 0;
  logic [9:0]  firstLine;

  always #5 clock = ~clock;

  nonce_uart_tx #(.CLKS_PER_BIT(C)) dut (
    .clock (clock),
    .reset (reset),
    .send  (send),
    .nonce (nonce),
    .txd   (txd),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Sample and drive 1 time unit after the active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Byte k of the frame: nonce bytes MSB first, then the optional XOR byte.
  function automatic logic [7:0] frameByte(input logic [31:0] n, input int k);
    logic [7:0] b [4];
    b[0] = n[31:24];
    b[1] = n[23:16];
    b[2] = n[15:8];
    b[3] = n[7:0];
    if (k < 4) return b[k];
    return b[0] ^ b[1] ^ b[2] ^ b[3];
  endfunction

  // Expected line level at cycle i of a frame (i = 0 is the first start cycle).
  function automatic logic modelLine(input logic [31:0] n, input int i);
    int         k;
    int         pos;
    logic [7:0] b;
    k   = i / (10 * C);
    pos = (i % (10 * C)) / C;
    b   = frameByte(n, k);
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return b[pos - 1];
  endfunction

  task automatic idleCheck(input int n, input string tag);
    int bad = 0;
    repeat (n) begin
      tick();
      if (txd !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    check(tag, bad, 0);
  endtask

  // Call while sampling the first cycle of a frame. It returns while
  // sampling the done cycle.
  task automatic checkFrame(input string tag, input logic [31:0] expNonce,
                            input int pokeAt, input bit wiggle, input bit scramble);
    int         bad = 0;
    int         pos;
    int         k;
    logic [7:0] obs [NB];
    for (int j = 0; j < NB; j++) obs[j] = 8'h00;
    for (int i = 0; i < FRAME; i++) begin
      if (txd !== modelLine(expNonce, i) || busy !== 1'b1 || done !== 1'b0) bad++;
      if (i % C == C / 2) begin
        pos = (i % (10 * C)) / C;
        k   = i / (10 * C);
        if (pos >= 1 && pos <= 8) obs[k][pos - 1] = txd;
        if (i < 10 * C) firstLine[pos] = txd;
      end
      if (scramble) nonce = $urandom;
      if (wiggle) send = 1'($urandom_range(0, 1));
      if (pokeAt >= 0 && i == pokeAt - 1) send = 1'b0;
      if (pokeAt >= 0 && i == pokeAt) send = 1'b1;
      if ((wiggle || pokeAt >= 0) && i == FRAME - 1) send = 1'b0;
      tick();
    end
    check({tag, "_line"}, bad, 0);
    for (int j = 0; j < NB; j++)
      check($sformatf("%s_byte%0d", tag, j), obs[j], frameByte(expNonce, j));
    check({tag, "_done"}, done, 1);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_txd_end"}, txd, 1);
  endtask

  initial begin
    logic [31:0] expNonce;

    reset = 1'b1;
    send  = 1'b0;
    nonce = 32'h0;
    tick();
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    tick();
    reset = 1'b0;
    idleCheck(5, "idle0");

    // Basic frame.
    nonce = 32'h42A14695;
    send  = 1'b1;
    tick();
    send  = 1'b0;
    checkFrame("basic", 32'h42A14695, -1, 0, 0);
    check("basic_first_byte_line", firstLine, 10'b1010000100);
    idleCheck(10, "idle1");

    // Nonce stability: nonce changes right after the trigger.
    nonce = 32'h42A14695;
    send  = 1'b1;
    tick();
    send  = 1'b0;
    nonce = 32'hFFFFFFFF;
    checkFrame("stable", 32'h42A14695, -1, 0, 0);
    idleCheck(10, "idle2");

    // Mid-frame rise at cycle 80 is ignored, and a rise in the done cycle
    // starts a new frame on the next cycle.
    nonce = 32'h42A14695;
    send  = 1'b1;
    tick();
    send  = 1'b0;
    checkFrame("poke80", 32'h42A14695, 80, 0, 0);
    expNonce = 32'h13579BDF;
    nonce    = expNonce;
    send     = 1'b1;
    tick();
    send     = 1'b0;
    checkFrame("retrig", expNonce, -1, 0, 0);
    idleCheck(10, "idle3");

    // Randomized frames with a scrambled nonce and a toggling send in flight.
    for (int r = 0; r < 6; r++) begin
      expNonce = $urandom;
      nonce    = expNonce;
      send     = 1'b0;
      idleCheck($urandom_range(1, 20), $sformatf("rnd%0d_gap", r));
      send = 1'b1;
      tick();
      send = 1'b0;
      checkFrame($sformatf("rnd%0d", r), expNonce, -1, 1, 1);
    end
    idleCheck(10, "idle4");

    // send held high for 500 cycles gives exactly one frame.
    expNonce = 32'hA5C3_0F96;
    nonce    = expNonce;
    send     = 1'b1;
    tick();
    checkFrame("held", expNonce, -1, 0, 0);
    idleCheck(500 - FRAME - 1, "held_quiet");
    send = 1'b0;
    idleCheck(5, "idle5");

    // Reset mid-frame with send held high.
    nonce = 32'h42A14695;
    send  = 1'b1;
    tick();
    repeat (49) tick();
    reset = 1'b1;
    tick();
    check("midrst_txd", txd, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    reset = 1'b0;
    idleCheck(300, "midrst_quiet");
    send = 1'b0;
    tick();
    send = 1'b1;
    tick();
    send = 1'b0;
    checkFrame("after_rst", 32'h42A14695, -1, 0, 0);
    idleCheck(3, "idle6");

    // Reset while idle with send high at release.
    reset = 1'b1;
    send  = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    idleCheck(200, "idlerst_quiet");
    send = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
